// File: rtl/fibo_pkg.sv
// Shared types and constants for the Fibonacci requester and its golden model.
package fibo_pkg;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT,
    CHECK,
    REPORT
  } state_t;

  localparam int SIZE_DEFAULT    = 4;
  localparam int TIMEOUT_DEFAULT = 64;

  localparam int F0 = 0;
  localparam int F1 = 1;

endpackage

// File: rtl/fibo_requester_if.sv
// Command, calculator and result signals between the requester and its neighbours.
interface fibo_requester_if
  import fibo_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
);

  logic            cmd_valid;
  logic [SIZE-1:0] cmd_count;
  logic            cmd_ready;

  logic            start;
  logic [SIZE-1:0] count;
  logic            done;
  logic [SIZE-1:0] data;

  logic            res_valid;
  logic [SIZE-1:0] res_data;
  logic            res_err;
  logic            res_timeout;
  logic            res_ready;

  modport master (
    input  cmd_valid, cmd_count, done, data, res_ready,
    output cmd_ready, start, count, res_valid, res_data, res_err, res_timeout
  );

  modport slave (
    output cmd_valid, cmd_count, done, data, res_ready,
    input  cmd_ready, start, count, res_valid, res_data, res_err, res_timeout
  );

endinterface

// File: rtl/fibo_golden.sv
// Iterative Fibonacci reference: two-register add with wrap, one iteration per cycle.
module fibo_golden
  import fibo_pkg::*;
#(
  parameter int SIZE = SIZE_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load,
  input  logic [SIZE-1:0] n,
  output logic [SIZE-1:0] value,
  output logic            done
);

  logic [SIZE-1:0] prev;
  logic [SIZE-1:0] cur;
  logic [SIZE-1:0] iter;
  logic [SIZE-1:0] target;

  // cur holds F(iter); index 0 is the only case where prev is the answer
  assign done  = (iter >= target);
  assign value = (target == '0) ? prev : cur;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev   <= '0;
      cur    <= '0;
      iter   <= '0;
      target <= '0;
    end else if (load) begin
      prev   <= SIZE'(F0);
      cur    <= SIZE'(F1);
      iter   <= SIZE'(1);
      target <= n;
    end else if (!done) begin
      prev <= cur;
      cur  <= prev + cur;
      iter <= iter + SIZE'(1);
    end
  end

endmodule

// File: rtl/fibo_requester.sv
// Issues requests to the Fibonacci calculator, captures DONE/DATA, checks against
// the golden model and reports result, mismatch and timeout on a valid/ready port.
module fibo_requester
  import fibo_pkg::*;
#(
  parameter int SIZE    = SIZE_DEFAULT,
  parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rst,
  fibo_requester_if.master     bus
);

  localparam int TW = $clog2(TIMEOUT) + 1;

  state_t          state;
  logic            done_q;
  logic [TW-1:0]   timer;
  logic            load;
  logic            done_edge;
  logic [SIZE-1:0] gold_value;
  logic            gold_done;

  assign bus.cmd_ready = (state == IDLE);
  assign load          = (state == IDLE) && bus.cmd_valid;
  assign done_edge     = bus.done & ~done_q;

  fibo_golden #(
    .SIZE (SIZE)
  ) u_golden (
    .clk   (clk),
    .rst   (rst),
    .load  (load),
    .n     (bus.cmd_count),
    .value (gold_value),
    .done  (gold_done)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= IDLE;
      done_q          <= 1'b0;
      timer           <= '0;
      bus.start       <= 1'b0;
      bus.count       <= '0;
      bus.res_valid   <= 1'b0;
      bus.res_data    <= '0;
      bus.res_err     <= 1'b0;
      bus.res_timeout <= 1'b0;
    end else begin
      done_q <= bus.done;
      unique case (state)
        IDLE: begin
          if (bus.cmd_valid) begin
            bus.count <= bus.cmd_count;
            bus.start <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          bus.start <= 1'b0;
          timer     <= '0;
          state     <= WAIT;
        end
        WAIT: begin
          // a DONE edge on the final timer cycle still counts as a completion
          if (done_edge) begin
            bus.res_data <= bus.data;
            if (gold_done) begin
              bus.res_err   <= (bus.data != gold_value);
              bus.res_valid <= 1'b1;
              state         <= REPORT;
            end else begin
              state <= CHECK;
            end
          end else if (timer == TW'(TIMEOUT - 1)) begin
            bus.res_timeout <= 1'b1;
            bus.res_err     <= 1'b0;
            bus.res_data    <= '0;
            bus.res_valid   <= 1'b1;
            state           <= REPORT;
          end else begin
            timer <= timer + TW'(1);
          end
        end
        CHECK: begin
          if (gold_done) begin
            bus.res_err   <= (bus.res_data != gold_value);
            bus.res_valid <= 1'b1;
            state         <= REPORT;
          end
        end
        REPORT: begin
          if (bus.res_ready) begin
            bus.res_valid   <= 1'b0;
            bus.res_err     <= 1'b0;
            bus.res_timeout <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fibo_requester.md
Name: fibo_requester

Overview:
- Initiator/consumer on the far side of the Fibonacci calculator's START/COUNT/DONE/DATA interface.
- Accepts commands from a valid/ready source and drives START and COUNT into the calculator.
- Detects DONE, captures DATA, and checks it against an internal iterative golden model.
- Presents the result, a mismatch flag and a timeout flag on a valid/ready result port; used for self-test and host sequencing.

Parameters:
- SIZE, 4, width of COUNT and DATA (must match the calculator's size).
- TIMEOUT, 64, maximum cycles in WAIT before the request is abandoned.

Ports:
- CLK  input  1  system clock, rising edge.
- RST  input  1  asynchronous, active-high reset.
- CMD_VALID  input  1  command present.
- CMD_COUNT  input  SIZE  requested Fibonacci index.
- CMD_READY  output  1  command accepted when high with CMD_VALID on the CLK edge.
- START  output  1  one-cycle start pulse to the calculator.
- COUNT  output  SIZE  index driven to the calculator.
- DONE  input  1  calculator completion level.
- DATA  input  SIZE  calculator result.
- RES_VALID  output  1  result available.
- RES_DATA  output  SIZE  captured DATA.
- RES_ERR  output  1  captured DATA != golden value.
- RES_TIMEOUT  output  1  no DONE within TIMEOUT cycles.
- RES_READY  input  1  result consumer ready.

Behaviour:
- One clock (CLK). Reset is asynchronous, active-high (RST); all state is cleared immediately on assertion.
- Reset values: state IDLE, START=0, COUNT=0, RES_VALID=0, RES_DATA=0, RES_ERR=0, RES_TIMEOUT=0, done_q=0, timer=0, golden cleared.
- CMD_READY = (state==IDLE), derived from state only; it reads 1 during and after reset.
- Golden value: F(0)=0, F(1)=1, F(n)=F(n-1)+F(n-2), computed mod 2^SIZE (adder wraps, no saturation).
- IDLE:
  - CMD_VALID & CMD_READY at edge k latches CMD_COUNT into COUNT, loads the golden model, and enters ISSUE.
- ISSUE (one cycle):
  - START=1 during cycle k+1 only; timer cleared; goes to WAIT.
- WAIT:
  - START=0. COUNT is held stable until leaving CHECK.
  - Golden model advances one iteration per cycle; it needs max(COUNT-1,0) cycles to finish.
  - DONE is accepted on a rising edge only: DONE & ~done_q, where done_q is DONE registered every cycle.
  - A DONE that is already high from a previous operation is ignored until it falls and rises again.
  - On an accepted edge, DATA is latched into RES_DATA and the state moves to CHECK.
  - Timer increments each WAIT cycle. If timer reaches TIMEOUT-1 with no edge, go to REPORT with RES_TIMEOUT=1, RES_ERR=0, RES_DATA=0.
  - If a DONE edge and the timeout occur in the same cycle, the DONE edge wins.
- CHECK:
  - Waits for golden done; this can take 0 extra cycles if the golden model has already finished.
  - Then RES_ERR=(RES_DATA!=golden) and the state moves to REPORT.
- REPORT:
  - RES_VALID=1; RES_DATA, RES_ERR and RES_TIMEOUT are held stable while RES_VALID & ~RES_READY.
  - On RES_VALID & RES_READY: RES_VALID=0 and the state returns to IDLE; RES_ERR and RES_TIMEOUT clear to 0 on the same edge.
  - The next command can be accepted on the following edge.
- Minimum request-to-result latency: handshake at edge k gives START in cycle k+1; DONE edge sampled at edge j gives RES_VALID from cycle j+1 (if golden done) or later.
- Reset mid-operation: START drops immediately, no partial result is presented, and the state returns to IDLE.
- CMD_VALID outside IDLE is ignored; nothing is queued.

Decomposition:
- Shared package fibo_pkg:
  - state enum {IDLE, ISSUE, WAIT, CHECK, REPORT};
  - default SIZE=4 and TIMEOUT=64 constants;
  - golden-model init constants F0=0, F1=1.
- One sub-module, fibo_golden: inputs CLK, RST, load, n[SIZE-1:0]; outputs value[SIZE-1:0], done. It implements the iterative two-register add with wrap.

Test Plan:
- COUNT=6; calculator model raises DONE with DATA=8 seven cycles after START -> RES_VALID with RES_DATA=8, RES_ERR=0, RES_TIMEOUT=0; START high exactly 1 cycle.
- COUNT=9; model returns 2 (34 mod 16) -> RES_ERR=0. Model returns 3 -> RES_DATA=3, RES_ERR=1.
- COUNT=0 and COUNT=1 -> golden 0 and 1. DONE edge on the first WAIT cycle -> CHECK takes no extra wait; result correct.
- DONE never rises -> after 64 WAIT cycles: RES_VALID=1, RES_TIMEOUT=1, RES_DATA=0. DONE held high from a prior op and never re-rising also times out.
- RES_READY low for 5 cycles in REPORT -> RES_VALID and data stable, CMD_READY=0, a new CMD_VALID is ignored. On RES_READY=1 -> next edge CMD_READY=1.
- RST pulsed asynchronously mid-WAIT (COUNT=5) -> START=0, RES_VALID=0, CMD_READY=1 immediately. A following COUNT=5 request completes with RES_DATA=5, RES_ERR=0.
